// File: rtl/c1_conv_mac_if.sv
// c1_conv_mac_if: handshake/bus bundle between the C1 MAC engine, its
// weight ROM / window buffer and the feature-map writer.
//   start, bias          : convolution request and its signed bias
//   busy                 : engine not idle
//   rom_raddr, rom_dout  : weight ROM address / signed weight (1-cycle latency)
//   win_raddr, win_dout  : window-buffer address / signed pixel (1-cycle latency)
//   result, result_valid : saturated signed result and its one-cycle pulse
// master = requester/memory side, slave = MAC engine.
interface c1_conv_mac_if #(
   parameter int PARA_WIDTH = 16,
   parameter int DATA_WIDTH = 16,
   parameter int OUT_WIDTH  = 16
);
   logic                  start;
   logic [OUT_WIDTH-1:0]  bias;
   logic                  busy;
   logic [4:0]            rom_raddr;
   logic [PARA_WIDTH-1:0] rom_dout;
   logic [4:0]            win_raddr;
   logic [DATA_WIDTH-1:0] win_dout;
   logic [OUT_WIDTH-1:0]  result;
   logic                  result_valid;

   modport master (
      output start, bias, rom_dout, win_dout,
      input  busy, rom_raddr, win_raddr, result, result_valid
   );

   modport slave (
      input  start, bias, rom_dout, win_dout,
      output busy, rom_raddr, win_raddr, result, result_valid
   );
endinterface

// File: rtl/c1_conv_mac.sv
// c1_conv_mac: conv-layer-1 multiply-accumulate engine. Per accepted start it
// walks addresses 0..KERNEL_SIZE-1 over the weight ROM and window buffer,
// accumulates the full-precision signed products onto the shifted bias, then
// emits one saturated Q(FRAC_BITS) result with a single-cycle valid pulse.
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : c1_conv_mac_if slave (start/bias in, addresses out, ROM/window
//         data in, busy/result/result_valid out)
module c1_conv_mac #(
   parameter int PARA_WIDTH  = 16,
   parameter int DATA_WIDTH  = 16,
   parameter int KERNEL_SIZE = 25,
   parameter int FRAC_BITS   = 8,
   parameter int ACC_WIDTH   = 40,
   parameter int OUT_WIDTH   = 16
) (
   input  logic clk,
   input  logic rst,
   c1_conv_mac_if.slave bus
);
   localparam int PROD_WIDTH = PARA_WIDTH + DATA_WIDTH;
   localparam logic [4:0] LAST_ADDR = 5'(KERNEL_SIZE - 1);
   localparam logic signed [ACC_WIDTH-1:0] MAX_VAL =
      {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_WIDTH-1:0] MIN_VAL =
      {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t                        state, next_state;
   logic [4:0]                    addr;
   logic                          drain_cnt;
   logic                          acc_en;
   logic signed [ACC_WIDTH-1:0]   acc;
   logic [OUT_WIDTH-1:0]          result_q;
   logic                          valid_q;

   logic                          accept, issue, step_addr, in_drain, drain_last, busy;
   logic signed [PROD_WIDTH-1:0]  prod;
   logic signed [ACC_WIDTH-1:0]   prod_ext, bias_ext, shifted;
   logic [OUT_WIDTH-1:0]          sat;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   // Next-state logic
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (bus.start)         next_state = RUN;
         RUN:     if (addr == LAST_ADDR) next_state = DRAIN;
         DRAIN:   if (drain_cnt)         next_state = DONE;
         DONE:                           next_state = IDLE;
         default:                        next_state = IDLE;
      endcase
   end

   // Control outputs
   always_comb begin
      busy       = (state != IDLE);
      accept     = (state == IDLE) && bus.start;
      issue      = (state == RUN);
      step_addr  = (state == RUN) && (addr != LAST_ADDR);
      in_drain   = (state == DRAIN);
      drain_last = (state == DRAIN) && drain_cnt;
   end

   // Arithmetic
   always_comb begin
      prod     = $signed(bus.rom_dout) * $signed(bus.win_dout);
      prod_ext = {{(ACC_WIDTH-PROD_WIDTH){prod[PROD_WIDTH-1]}}, prod};
      bias_ext = {{(ACC_WIDTH-OUT_WIDTH){bus.bias[OUT_WIDTH-1]}}, bus.bias} <<< FRAC_BITS;
      shifted  = acc >>> FRAC_BITS;
      if (shifted > MAX_VAL)      sat = {1'b0, {(OUT_WIDTH-1){1'b1}}};
      else if (shifted < MIN_VAL) sat = {1'b1, {(OUT_WIDTH-1){1'b0}}};
      else                        sat = shifted[OUT_WIDTH-1:0];
   end

   // Datapath. acc_en marks that the ROM/window data currently on the inputs
   // belongs to an address issued during RUN one edge earlier.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr      <= '0;
         drain_cnt <= 1'b0;
         acc_en    <= 1'b0;
         acc       <= '0;
         result_q  <= '0;
         valid_q   <= 1'b0;
      end else begin
         acc_en  <= issue;
         valid_q <= drain_last;
         if (accept) begin
            acc       <= bias_ext;
            addr      <= '0;
            drain_cnt <= 1'b0;
         end else begin
            if (acc_en)    acc       <= acc + prod_ext;
            if (step_addr) addr      <= addr + 5'd1;
            if (in_drain)  drain_cnt <= 1'b1;
         end
         if (drain_last) result_q <= sat;
      end
   end

   assign bus.busy         = busy;
   assign bus.rom_raddr    = addr;
   assign bus.win_raddr    = addr;
   assign bus.result       = result_q;
   assign bus.result_valid = valid_q;
endmodule
